// File: rtl/dll_cal_pkg.sv
// Shared types and constants for the DLL tap calibrator.
package dll_cal_pkg;

    localparam int TAP_W = 8;
    localparam logic [TAP_W-1:0] TAP_MIN = 8'd1;
    localparam logic [TAP_W-1:0] TAP_MAX = 8'd255;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETTLE = 3'd1,
        SAMPLE = 3'd2,
        DECIDE = 3'd3,
        LOCKED = 3'd4,
        TRACK  = 3'd5
    } cal_state_e;

    function automatic logic [TAP_W-1:0] half_tap(input logic [TAP_W-1:0] tap);
        return {1'b0, tap[TAP_W-1:1]};
    endfunction

endpackage

// File: rtl/dll_pd_filter.sv
// Phase-detector front end: 2-flop synchronizer and a SAMPLE_NUM-long voting window.
module dll_pd_filter #(
    parameter int SAMPLE_NUM = 4
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_pd_late,
    input  logic i_win_start,
    output logic o_done,
    output logic o_all_late,
    output logic o_all_early
);

    localparam logic [3:0] LAST_IDX = 4'(SAMPLE_NUM - 1);

    logic       sync1_r;
    logic       sync2_r;
    logic       pd_s;
    logic       active_r;
    logic [3:0] cnt_r;
    logic       late_acc_r;
    logic       early_acc_r;
    logic       all_late_r;
    logic       all_early_r;
    logic       last_s;

    assign pd_s   = sync2_r;
    assign last_s = active_r && (cnt_r == LAST_IDX);

    // Synchronize the asynchronous phase-detector output.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
        end else begin
            sync1_r <= i_pd_late;
            sync2_r <= sync1_r;
        end
    end

    // Window starts the cycle after the strobe; verdict registers on the last sample.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            active_r    <= 1'b0;
            cnt_r       <= 4'd0;
            late_acc_r  <= 1'b0;
            early_acc_r <= 1'b0;
            all_late_r  <= 1'b0;
            all_early_r <= 1'b0;
        end else if (i_win_start) begin
            active_r    <= 1'b1;
            cnt_r       <= 4'd0;
            late_acc_r  <= 1'b1;
            early_acc_r <= 1'b1;
        end else if (active_r) begin
            if (last_s) begin
                active_r    <= 1'b0;
                cnt_r       <= 4'd0;
                all_late_r  <= late_acc_r & pd_s;
                all_early_r <= early_acc_r & ~pd_s;
            end else begin
                cnt_r       <= cnt_r + 4'd1;
                late_acc_r  <= late_acc_r & pd_s;
                early_acc_r <= early_acc_r & ~pd_s;
            end
        end
    end

    assign o_done      = last_s;
    assign o_all_late  = all_late_r;
    assign o_all_early = all_early_r;

endmodule

// File: rtl/dll_tap_calibrator.sv
// Master-DLL tap sweep / lock controller. Optional lock tracking under DLL_TRACK_EN.
module dll_tap_calibrator
    import dll_cal_pkg::*;
#(
    parameter int SETTLE_CYCLES = 8,
    parameter int SAMPLE_NUM    = 4,
    parameter int INIT_TAP      = 1
`ifdef DLL_TRACK_EN
    ,
    parameter int TRACK_PERIOD  = 256
`endif
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic             i_pd_late,
    output logic [TAP_W-1:0] o_sel_index,
    output logic [TAP_W-1:0] o_half_index,
    output logic             o_busy,
    output logic             o_lock,
    output logic             o_err
);

    localparam logic [TAP_W-1:0] INIT_TAP_L  = TAP_W'(INIT_TAP);
    localparam logic [7:0]       SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

    cal_state_e       state_r, state_n_s;
    logic [TAP_W-1:0] tap_r, tap_n_s;
    logic [7:0]       settle_cnt_r, settle_cnt_n_s;
    logic             busy_r, busy_n_s;
    logic             lock_r, lock_n_s;
    logic             err_r, err_n_s;
    logic             win_start_s;
    logic             done_s;
    logic             all_late_s;
    logic             start_ok_s;
`ifdef DLL_TRACK_EN
    localparam int TCW = (TRACK_PERIOD > 1) ? $clog2(TRACK_PERIOD) : 1;
    localparam logic [TCW-1:0] TRACK_LAST = TCW'(TRACK_PERIOD - 1);

    logic           all_early_s;
    logic [TCW-1:0] track_cnt_r, track_cnt_n_s;
    logic [7:0]     holdoff_r, holdoff_n_s;
    logic           apply_r, apply_n_s;
`endif

    dll_pd_filter #(
        .SAMPLE_NUM(SAMPLE_NUM)
    ) u_pd_filter (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_pd_late  (i_pd_late),
        .i_win_start(win_start_s),
        .o_done     (done_s),
        .o_all_late (all_late_s),
`ifdef DLL_TRACK_EN
        .o_all_early(all_early_s)
`else
        .o_all_early()
`endif
    );

    assign start_ok_s = i_start && !busy_r;

    // Next-state, tap and status logic.
    always_comb begin
        state_n_s      = state_r;
        tap_n_s        = tap_r;
        settle_cnt_n_s = settle_cnt_r;
        busy_n_s       = busy_r;
        lock_n_s       = lock_r;
        err_n_s        = err_r;
        win_start_s    = 1'b0;
`ifdef DLL_TRACK_EN
        track_cnt_n_s  = track_cnt_r;
        holdoff_n_s    = holdoff_r;
        apply_n_s      = apply_r;
`endif
        if (start_ok_s) begin
            state_n_s      = SETTLE;
            tap_n_s        = INIT_TAP_L;
            settle_cnt_n_s = 8'd0;
            busy_n_s       = 1'b1;
            lock_n_s       = 1'b0;
            err_n_s        = 1'b0;
`ifdef DLL_TRACK_EN
            track_cnt_n_s  = '0;
            holdoff_n_s    = 8'd0;
            apply_n_s      = 1'b0;
`endif
        end else begin
            case (state_r)
                IDLE: state_n_s = IDLE;
                SETTLE: begin
                    if (settle_cnt_r == SETTLE_LAST) begin
                        settle_cnt_n_s = 8'd0;
                        win_start_s    = 1'b1;
                        state_n_s      = SAMPLE;
                    end else begin
                        settle_cnt_n_s = settle_cnt_r + 8'd1;
                    end
                end
                SAMPLE: begin
                    if (done_s) begin
                        state_n_s = DECIDE;
                    end else begin
                        state_n_s = SAMPLE;
                    end
                end
                DECIDE: begin
                    if (all_late_s) begin
                        state_n_s = LOCKED;
                        lock_n_s  = 1'b1;
                        busy_n_s  = 1'b0;
`ifdef DLL_TRACK_EN
                        track_cnt_n_s = '0;
                        holdoff_n_s   = 8'd0;
                        apply_n_s     = 1'b0;
`endif
                    end else if (tap_r < TAP_MAX) begin
                        tap_n_s   = tap_r + 8'd1;
                        state_n_s = SETTLE;
                    end else begin
                        err_n_s   = 1'b1;
                        busy_n_s  = 1'b0;
                        state_n_s = IDLE;
                    end
                end
`ifdef DLL_TRACK_EN
                LOCKED: begin
                    track_cnt_n_s = (track_cnt_r == TRACK_LAST) ? '0 : track_cnt_r + 1'b1;
                    if (apply_r) begin
                        // Verdict from the window that just closed in TRACK.
                        apply_n_s = 1'b0;
                        if (all_late_s && (tap_r > TAP_MIN)) begin
                            tap_n_s     = tap_r - 8'd1;
                            holdoff_n_s = 8'(SETTLE_CYCLES);
                        end else if (all_early_s && (tap_r < TAP_MAX)) begin
                            tap_n_s     = tap_r + 8'd1;
                            holdoff_n_s = 8'(SETTLE_CYCLES);
                        end else begin
                            tap_n_s = tap_r;
                        end
                    end else if (holdoff_r != 8'd0) begin
                        holdoff_n_s = holdoff_r - 8'd1;
                    end else if (track_cnt_r == TRACK_LAST) begin
                        win_start_s = 1'b1;
                        state_n_s   = TRACK;
                    end else begin
                        state_n_s = LOCKED;
                    end
                end
                TRACK: begin
                    track_cnt_n_s = (track_cnt_r == TRACK_LAST) ? '0 : track_cnt_r + 1'b1;
                    if (done_s) begin
                        apply_n_s = 1'b1;
                        state_n_s = LOCKED;
                    end else begin
                        state_n_s = TRACK;
                    end
                end
`else
                LOCKED: state_n_s = LOCKED;
`endif
                default: state_n_s = IDLE;
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r      <= IDLE;
            tap_r        <= INIT_TAP_L;
            settle_cnt_r <= 8'd0;
            busy_r       <= 1'b0;
            lock_r       <= 1'b0;
            err_r        <= 1'b0;
`ifdef DLL_TRACK_EN
            track_cnt_r  <= '0;
            holdoff_r    <= 8'd0;
            apply_r      <= 1'b0;
`endif
        end else begin
            state_r      <= state_n_s;
            tap_r        <= tap_n_s;
            settle_cnt_r <= settle_cnt_n_s;
            busy_r       <= busy_n_s;
            lock_r       <= lock_n_s;
            err_r        <= err_n_s;
`ifdef DLL_TRACK_EN
            track_cnt_r  <= track_cnt_n_s;
            holdoff_r    <= holdoff_n_s;
            apply_r      <= apply_n_s;
`endif
        end
    end

    assign o_sel_index  = tap_r;
    assign o_half_index = half_tap(tap_r);
    assign o_busy       = busy_r;
    assign o_lock       = lock_r;
    assign o_err        = err_r;

endmodule

// File: tb/tb_dll_tap_calibrator.sv
// Directed bench for dll_tap_calibrator: sweep table plus restart/reset/lock-hold sequences.
module tb_dll_tap_calibrator;

    logic       i_clk = 1'b0;
    logic       i_rst_n;
    logic       i_start;
    logic       i_pd_late;
    logic [7:0] o_sel_index;
    logic [7:0] o_half_index;
    logic       o_busy;
    logic       o_lock;
    logic       o_err;

    int checks = 0;
    int errors = 0;

    // PD model controls: 0 = threshold/noisy model, 1 = random, 2 = always 0, 3 = always 1
    int   pd_mode   = 0;
    int   late_from = 256;
    int   noisy_tap = 0;
    logic toggle_r  = 1'b0;

    typedef struct {
        int late_from;
        int noisy_tap;
        int exp_tap;
        int exp_half;
        int exp_lock;
        int exp_err;
        int exp_cycles;
    } row_t;

    row_t rows[5];

    dll_tap_calibrator dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_start     (i_start),
        .i_pd_late   (i_pd_late),
        .o_sel_index (o_sel_index),
        .o_half_index(o_half_index),
        .o_busy      (o_busy),
        .o_lock      (o_lock),
        .o_err       (o_err)
    );

    always #5 i_clk = ~i_clk;

    always @(negedge i_clk) begin
        toggle_r <= ~toggle_r;
        case (pd_mode)
            0: begin
                if (noisy_tap != 0 && int'(o_sel_index) == noisy_tap)
                    i_pd_late <= toggle_r;
                else
                    i_pd_late <= (int'(o_sel_index) >= late_from);
            end
            1:       i_pd_late <= 1'($urandom_range(0, 1));
            2:       i_pd_late <= 1'b0;
            default: i_pd_late <= 1'b1;
        endcase
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic pulse_start();
        @(negedge i_clk);
        i_start = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
    endtask

    task automatic wait_idle(output int cycles);
        cycles = 0;
        while (o_busy && cycles < 5000) begin
            @(posedge i_clk);
            cycles++;
            @(negedge i_clk);
        end
    endtask

    initial begin
        int cycles;
        int lock_ok;
        int start_tap;

        // late_from, noisy_tap, tap, half, lock, err, cycles (13 cycles per failing tap)
        rows[0] = '{37,  0,  37,  18, 1, 0, 36 * 13 + 13};
        rows[1] = '{1,   0,  1,   0,  1, 0, 13};
        rows[2] = '{255, 0,  255, 127, 1, 0, 254 * 13 + 13};
        rows[3] = '{256, 0,  255, 127, 0, 1, 254 * 13 + 13};
        rows[4] = '{38,  37, 38,  19, 1, 0, 37 * 13 + 13};

        i_rst_n   = 1'b0;
        i_start   = 1'b0;
        i_pd_late = 1'b0;
        repeat (3) @(negedge i_clk);
        check("reset_sel", int'(o_sel_index), 1);
        check("reset_half", int'(o_half_index), 0);
        check("reset_busy", int'(o_busy), 0);
        check("reset_lock", int'(o_lock), 0);
        check("reset_err", int'(o_err), 0);
        i_rst_n = 1'b1;
        repeat (2) @(negedge i_clk);

        for (int r = 0; r < 5; r++) begin
            pd_mode   = 0;
            late_from = rows[r].late_from;
            noisy_tap = rows[r].noisy_tap;
            pulse_start();
            check($sformatf("row%0d_busy_start", r), int'(o_busy), 1);
            check($sformatf("row%0d_err_cleared", r), int'(o_err), 0);
            check($sformatf("row%0d_sel_start", r), int'(o_sel_index), 1);
            wait_idle(cycles);
            check($sformatf("row%0d_cycles", r), cycles, rows[r].exp_cycles);
            check($sformatf("row%0d_sel", r), int'(o_sel_index), rows[r].exp_tap);
            check($sformatf("row%0d_half", r), int'(o_half_index), rows[r].exp_half);
            check($sformatf("row%0d_lock", r), int'(o_lock), rows[r].exp_lock);
            check($sformatf("row%0d_err", r), int'(o_err), rows[r].exp_err);
            check($sformatf("row%0d_busy_end", r), int'(o_busy), 0);
        end

        // i_start mid-sweep must not disturb the tap sequence.
        pd_mode   = 0;
        late_from = 37;
        noisy_tap = 0;
        pulse_start();
        cycles = 0;
        while (o_busy && cycles < 5000) begin
            @(posedge i_clk);
            cycles++;
            @(negedge i_clk);
            i_start = (cycles == 100);
        end
        i_start = 1'b0;
        check("ignore_start_cycles", cycles, 36 * 13 + 13);
        check("ignore_start_sel", int'(o_sel_index), 37);
        check("ignore_start_lock", int'(o_lock), 1);

        // Restart from lock: lock drops right away and the sweep begins at tap 1.
        pulse_start();
        check("relock_lock_drop", int'(o_lock), 0);
        check("relock_busy", int'(o_busy), 1);
        check("relock_sel", int'(o_sel_index), 1);

        // Asynchronous reset while sweeping at tap 20.
        cycles = 0;
        while (int'(o_sel_index) != 20 && cycles < 1000) begin
            @(negedge i_clk);
            cycles++;
        end
        check("reach_tap20", int'(o_sel_index), 20);
        #2 i_rst_n = 1'b0;
        #1;
        check("mid_reset_sel", int'(o_sel_index), 1);
        check("mid_reset_half", int'(o_half_index), 0);
        check("mid_reset_busy", int'(o_busy), 0);
        check("mid_reset_lock", int'(o_lock), 0);
        check("mid_reset_err", int'(o_err), 0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        repeat (50) @(negedge i_clk);
        check("post_reset_idle_busy", int'(o_busy), 0);
        check("post_reset_idle_lock", int'(o_lock), 0);
        check("post_reset_idle_sel", int'(o_sel_index), 1);

        // Lock again at 37 before the lock-hold sequence.
        pulse_start();
        wait_idle(cycles);
        check("hold_prelock_sel", int'(o_sel_index), 37);
        check("hold_prelock_lock", int'(o_lock), 1);

`ifdef DLL_TRACK_EN
        // PD early: tracking steps the tap up by one without dropping lock.
        pd_mode = 2;
        lock_ok = 1;
        cycles  = 0;
        while (int'(o_sel_index) == 37 && cycles < 600) begin
            @(negedge i_clk);
            cycles++;
            if (!o_lock || o_busy) lock_ok = 0;
        end
        check("track_up_sel", int'(o_sel_index), 38);
        check("track_up_half", int'(o_half_index), 19);
        check("track_up_lock_held", lock_ok, 1);

        // PD late: tracking walks down and clamps at tap 1.
        pd_mode = 3;
        cycles  = 0;
        while (int'(o_sel_index) != 1 && cycles < 12000) begin
            @(negedge i_clk);
            cycles++;
            if (!o_lock || o_busy) lock_ok = 0;
        end
        check("track_down_reach1", int'(o_sel_index), 1);
        repeat (800) begin
            @(negedge i_clk);
            if (!o_lock || o_busy) lock_ok = 0;
        end
        check("track_clamp_sel", int'(o_sel_index), 1);
        check("track_lock_held", lock_ok, 1);
`else
        // Without tracking the locked tap is frozen regardless of PD activity.
        pd_mode   = 1;
        lock_ok   = 1;
        start_tap = int'(o_sel_index);
        repeat (5000) begin
            @(negedge i_clk);
            if (!o_lock || o_busy || int'(o_sel_index) != start_tap) lock_ok = 0;
        end
        check("frozen_sel", int'(o_sel_index), 37);
        check("frozen_half", int'(o_half_index), 18);
        check("frozen_stable", lock_ok, 1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
